icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction word and word-address width.
REQ-002 Parameter NUM_LINES, default 16, line count; power of two, >= 2.
REQ-003 Parameter WORDS_PER_LINE, default 4, words per line; power of two, >= 2.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 Port ptr  input  WORD_SIZE  word address of the requested instruction.
REQ-007 Port inst_get  input  1  fetch request; ptr is held stable by the requester until is_ready.
REQ-008 Port flush  input  1  invalidate all lines.
REQ-009 Port out  output  WORD_SIZE  fetched instruction; valid when is_ready=1.
REQ-010 Port is_ready  output  1  one-cycle pulse per completed fetch.
REQ-011 Port mem_req  output  1  refill request to backing memory.
REQ-012 Port mem_addr  output  WORD_SIZE  word address of the current refill beat.
REQ-013 Port mem_data  input  WORD_SIZE  refill data.
REQ-014 Port mem_valid  input  1  mem_data valid this cycle; counts only while mem_req=1.
REQ-015 Port hit_count  output  32  completed hits, wraps modulo 2^32.
REQ-016 Port miss_count  output  32  accepted misses, wraps modulo 2^32.

Function
REQ-017 Direct-mapped; OB=log2(WORDS_PER_LINE), IB=log2(NUM_LINES); offset=ptr[OB-1:0], index=ptr[OB+IB-1:OB], tag=ptr[WORD_SIZE-1:OB+IB].
REQ-018 Per-line storage: valid bit, tag, WORDS_PER_LINE data words.
REQ-019 States: IDLE, REFILL.
REQ-020 IDLE, flush=1: clear all valid bits; inst_get ignored that cycle; is_ready=0 next cycle.
REQ-021 IDLE, inst_get=1, line valid and tag equal (hit): next cycle out=stored word, is_ready=1, hit_count+1; stay IDLE.
REQ-022 Hit latency 1 cycle; back-to-back hits sustain one is_ready per cycle.
REQ-023 IDLE, inst_get=1, miss: latch tag/index/offset, beat=0, miss_count+1, enter REFILL; is_ready=0.
REQ-024 REFILL: mem_req=1; mem_addr={latched tag, latched index, beat}.
REQ-025 REFILL, mem_valid=1: write mem_data to word[beat], beat+1; mem_valid=0 holds beat and mem_addr.
REQ-026 Last beat (beat=WORDS_PER_LINE-1 with mem_valid): set valid/tag; next cycle out=latched-offset word (mem_data if offset is last), is_ready=1, mem_req=0, state IDLE.
REQ-027 Full line always fetched in order 0..WORDS_PER_LINE-1; no early critical-word return.
REQ-028 inst_get and ptr ignored during REFILL; requester still holds them.
REQ-029 flush during REFILL latched as pending; on refill completion all valid bits cleared, including the refilled line; is_ready/out still delivered.
REQ-030 Idle, no request: is_ready=0; out holds last value.
REQ-031 Refill over a valid line with a different tag replaces it; no write-back (read-only).

Reset
REQ-032 rst_n=0 asynchronously: state IDLE, all valid bits 0, out=0, is_ready=0, mem_req=0, mem_addr=0, beat=0, pending flush=0, hit_count=0, miss_count=0.
REQ-033 Reset mid-REFILL aborts the refill immediately; mem_req drops without waiting for clk; partly filled line stays invalid.
REQ-034 Data array contents need not be reset.

Verification (NUM_LINES=16, WORDS_PER_LINE=4, WORD_SIZE=32)
REQ-035 Cold miss: ptr=1, inst_get=1; memory returns 0xA0..0xA3 -> mem_addr 0,1,2,3; one cycle after beat 3 is_ready=1, out=0xA1, miss_count=1.
REQ-036 Hit: then ptr=2, 3 back-to-back -> is_ready on consecutive cycles, out=0xA2 then 0xA3, hit_count=2, mem_req stays 0.
REQ-037 Conflict: ptr=0x41 (index 0, tag 1) -> miss, mem_addr 0x40..0x43; then ptr=1 misses again, miss_count=3.
REQ-038 Stall: mem_valid low 3 cycles between beats 1 and 2 -> mem_addr holds at beat 2 address, is_ready delayed 3 cycles, out correct.
REQ-039 Flush: after line 0 fill, flush=1 in IDLE for one cycle, then ptr=1 -> miss; flush during a refill -> data returned, same ptr re-requested misses.
REQ-040 Reset mid-refill: rst_n=0 after 2 beats -> mem_req=0, is_ready=0, counters=0 immediately; after release ptr=1 misses and refills from mem_addr 0.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with in-order full-line refill.
// Hits return in one cycle; misses stream WORDS_PER_LINE beats from memory.
module icache_dm #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] ptr,
  input  logic                 inst_get,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] out,
  output logic                 is_ready,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_valid,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic                 dbg_state_o
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = WORD_SIZE - OB - IB;
  localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TW-1:0]          tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0]   data_q [NUM_LINES*WORDS_PER_LINE];
  logic [TW-1:0]          lat_tag_q;
  logic [IB-1:0]          lat_idx_q;
  logic [OB-1:0]          lat_off_q;
  logic [OB-1:0]          beat_q;
  logic                   flush_pend_q;
  logic [WORD_SIZE-1:0]   out_q;
  logic                   is_ready_q;
  logic                   mem_req_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [31:0]            hit_count_q;
  logic [31:0]            miss_count_q;

  logic [TW-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic          hit;
  logic          beat_wr;
  logic          last_beat;
  logic [OB-1:0] beat_d;

  assign req_tag   = ptr[WORD_SIZE-1:OB+IB];
  assign req_idx   = ptr[OB+IB-1:OB];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign beat_wr   = (state_q == REFILL) && mem_valid;
  assign last_beat = beat_wr && (beat_q == LAST_BEAT);
  assign beat_d    = beat_q + OB'(1);

  // Data and tags carry no reset: the valid bits alone decide whether a line counts.
  always_ff @(posedge clk) begin
    if (beat_wr) data_q[{lat_idx_q, beat_q}] <= mem_data;
    if (last_beat) tag_q[lat_idx_q] <= lat_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      lat_tag_q    <= '0;
      lat_idx_q    <= '0;
      lat_off_q    <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      out_q        <= '0;
      is_ready_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      is_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (inst_get) begin
            if (hit) begin
              out_q       <= data_q[ptr[OB+IB-1:0]];
              is_ready_q  <= 1'b1;
              hit_count_q <= hit_count_q + 32'd1;
            end else begin
              lat_tag_q    <= req_tag;
              lat_idx_q    <= req_idx;
              lat_off_q    <= ptr[OB-1:0];
              beat_q       <= '0;
              miss_count_q <= miss_count_q + 32'd1;
              mem_req_q    <= 1'b1;
              mem_addr_q   <= {ptr[WORD_SIZE-1:OB], {OB{1'b0}}};
              state_q      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_valid) begin
            if (beat_q == LAST_BEAT) begin
              // A flush seen at any point of the refill also drops the new line.
              if (flush_pend_q || flush) valid_q <= '0;
              else                       valid_q[lat_idx_q] <= 1'b1;
              flush_pend_q <= 1'b0;
              out_q        <= (lat_off_q == LAST_BEAT) ? mem_data
                                                       : data_q[{lat_idx_q, lat_off_q}];
              is_ready_q   <= 1'b1;
              mem_req_q    <= 1'b0;
              beat_q       <= '0;
              state_q      <= IDLE;
            end else begin
              beat_q     <= beat_d;
              mem_addr_q <= {lat_tag_q, lat_idx_q, beat_d};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out         = out_q;
  assign is_ready    = is_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed vector table, hand-written reset/idle sequences,
// and randomized fetches checked against an array-based cache/memory model.
module tb_icache_dm;

  logic        clk;
  logic        rst_n;
  logic [31:0] ptr;
  logic        inst_get;
  logic        flush;
  logic [31:0] out;
  logic        is_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        dbg_state;

  icache_dm #(.WORD_SIZE(32), .NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ptr        (ptr),
    .inst_get   (inst_get),
    .flush      (flush),
    .out        (out),
    .is_ready   (is_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;
  bit          m_valid [16];
  logic [25:0] m_tag   [16];

  typedef struct {
    logic [31:0] p;
    int          mode;
    bit          flush_mid;
    bit          idle_flush;
    bit          exp_hit;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  function automatic bit model_hit(input logic [31:0] p);
    return m_valid[p[5:2]] && (m_tag[p[5:2]] == p[31:6]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one fetch starting at a negedge, ending at the negedge where is_ready
  // is due. mode 0 = memory always valid, 1 = random gaps, 2 = 3-cycle stall before beat 2.
  task automatic fetch(input logic [31:0] p, input int mode, input bit flush_mid,
                       input bit exp_hit, input logic [31:0] exp_out);
    int          beat = 0;
    int          cycles = 0;
    int          stalls = 0;
    bit          v;
    logic [1:0]  b2;
    logic [31:0] want;
    ptr       = p;
    inst_get  = 1'b1;
    flush     = 1'b0;
    mem_valid = 1'b0;
    exp_q.push_back(exp_out);
    @(negedge clk);
    if (exp_hit) begin
      exp_hits++;
      check("hit_ready", {31'b0, is_ready}, 32'd1);
      check("hit_mem_req", {31'b0, mem_req}, 32'd0);
      want = exp_q.pop_front();
      check("hit_out", out, want);
      last_exp = want;
      return;
    end
    exp_misses++;
    check("miss_ready_low", {31'b0, is_ready}, 32'd0);
    while (beat < 4 && cycles < 100) begin
      b2 = beat[1:0];
      check("refill_req", {31'b0, mem_req}, 32'd1);
      check("refill_addr", mem_addr, {p[31:2], b2});
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = !(beat == 2 && stalls < 3);
      endcase
      if (!v) stalls++;
      mem_valid = v;
      mem_data  = mem_word({p[31:2], b2});
      flush     = flush_mid && (cycles == 1);
      @(negedge clk);
      if (v) beat++;
      cycles++;
      if (beat < 4) check("refill_ready_low", {31'b0, is_ready}, 32'd0);
    end
    mem_valid = 1'b0;
    flush     = 1'b0;
    if (beat < 4) check("refill_timeout_beats", beat, 4);
    if (mode == 2) check("stall_count", stalls, 3);
    check("done_ready", {31'b0, is_ready}, 32'd1);
    check("done_mem_req", {31'b0, mem_req}, 32'd0);
    want = exp_q.pop_front();
    check("done_out", out, want);
    last_exp = want;
    if (flush_mid) model_clear();
    else begin
      m_valid[p[5:2]] = 1'b1;
      m_tag[p[5:2]]   = p[31:6];
    end
  endtask

  task automatic idle_flush();
    inst_get = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready_low", {31'b0, is_ready}, 32'd0);
    check("flush_out_hold", out, last_exp);
    model_clear();
  endtask

  task automatic idle_cycle();
    inst_get = 1'b0;
    @(negedge clk);
    check("idle_ready_low", {31'b0, is_ready}, 32'd0);
    check("idle_out_hold", out, last_exp);
    check("idle_mem_req", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hits"}, hit_count, exp_hits);
    check({tag, "_misses"}, miss_count, exp_misses);
  endtask

  initial begin
    logic [31:0] rp;
    bit          rf;
    vecs[0]  = '{32'h01, 0, 1'b0, 1'b0, 1'b0, 32'hA1};
    vecs[1]  = '{32'h02, 0, 1'b0, 1'b0, 1'b1, 32'hA2};
    vecs[2]  = '{32'h03, 0, 1'b0, 1'b0, 1'b1, 32'hA3};
    vecs[3]  = '{32'h41, 0, 1'b0, 1'b0, 1'b0, 32'hE1};
    vecs[4]  = '{32'h01, 0, 1'b0, 1'b0, 1'b0, 32'hA1};
    vecs[5]  = '{32'h02, 0, 1'b0, 1'b0, 1'b1, 32'hA2};
    vecs[6]  = '{32'h12, 2, 1'b0, 1'b0, 1'b0, 32'hB2};
    vecs[7]  = '{32'h01, 0, 1'b0, 1'b1, 1'b0, 32'hA1};
    vecs[8]  = '{32'h05, 0, 1'b1, 1'b0, 1'b0, 32'hA5};
    vecs[9]  = '{32'h05, 0, 1'b0, 1'b0, 1'b0, 32'hA5};
    vecs[10] = '{32'h01, 0, 1'b0, 1'b0, 1'b0, 32'hA1};
    vecs[11] = '{32'h23, 1, 1'b0, 1'b0, 1'b0, 32'hC3};

    rst_n     = 1'b0;
    ptr       = '0;
    inst_get  = 1'b0;
    flush     = 1'b0;
    mem_data  = '0;
    mem_valid = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_out", out, 32'h0);
    check("rst_ready", {31'b0, is_ready}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check_counters("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].idle_flush) idle_flush();
      fetch(vecs[i].p, vecs[i].mode, vecs[i].flush_mid, vecs[i].exp_hit, vecs[i].exp_out);
      if (i == 2 || i == 4) check_counters("table");
    end
    idle_cycle();
    check_counters("table_end");

    // Randomized fetches against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) idle_flush();
      rp = $urandom_range(0, 127);
      rf = ($urandom_range(0, 7) == 0);
      fetch(rp, $urandom_range(0, 1), rf, model_hit(rp), mem_word(rp));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    check_counters("random");

    // Reset in the middle of a refill
    idle_flush();
    ptr      = 32'h1;
    inst_get = 1'b1;
    @(negedge clk);
    check("rmid_req", {31'b0, mem_req}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_data  = mem_word(b);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rmid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rmid_ready", {31'b0, is_ready}, 32'd0);
    check("rmid_hits", hit_count, 32'd0);
    check("rmid_misses", miss_count, 32'd0);
    check("rmid_out", out, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    last_exp   = 32'h0;
    model_clear();
    fetch(32'h1, 0, 1'b0, 1'b0, 32'hA1);
    fetch(32'h0, 0, 1'b0, 1'b1, 32'hA0);
    idle_cycle();
    check_counters("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
